spi_slave_out: RTL

//  SPI slave transmitter: the far end of spi_master_in. Holds one word from the local side
//  and shifts it MSB-first on miso when an external master clocks it out.

---
 rtl/spi_slave_out_pkg.sv | 22 ++
 rtl/sync_edge.sv | 33 +++
 rtl/spi_slave_out.sv | 136 +++++++++++++
 3 files changed

// File: rtl/spi_slave_out_pkg.sv
// Shared SPI constants, FSM state type and frame-length helper for spi_slave_out.
// Optional parity bit: define SPI_SLAVE_OUT_PARITY_EN.
package spi_slave_out_pkg;

  localparam int unsigned SPI_CPOL            = 0;     // mode 0: sck idles low
  localparam bit          CS_ACTIVE_LOW       = 1'b1;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  function automatic int unsigned frame_len(input int unsigned bits);
`ifdef SPI_SLAVE_OUT_PARITY_EN
    return bits + 1;
`else
    return bits;
`endif
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous input plus rise/fall pulses
// derived from the synchronised level against a one-flop history.
module sync_edge
  import spi_slave_out_pkg::*;
#(
  parameter int unsigned STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;
  logic              level;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      hist  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      hist  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_slave_out.sv
// SPI mode-0 slave transmitter: one-word holding register shifted MSB-first on miso.
// Define SPI_SLAVE_OUT_PARITY_EN to append an odd-parity bit after the data LSB.
module spi_slave_out
  import spi_slave_out_pkg::*;
#(
  parameter int unsigned BITS        = 8,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sck,
  input  logic            cs_n,
  output logic            miso,
  input  logic [BITS-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            underrun
);

  localparam int unsigned     FW       = frame_len(BITS);
  localparam int unsigned     CW       = $clog2(FW + 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(FW);

  state_t          state, state_next;
  logic [BITS-1:0] holding, holding_next;
  logic            hold_full, hold_full_next;
  logic [FW-1:0]   shreg, shreg_next;
  logic [CW-1:0]   bitcnt, bitcnt_next;
  logic            done_next, aborted_next, underrun_next;

  logic            sck_rise, sck_fall, cs_rise, cs_fall;
  logic            frame_start, frame_end, sck_lead, sck_trail;
  logic [BITS-1:0] start_word;
  logic [FW-1:0]   start_frame;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk   (clk),
    .reset (reset),
    .din   (sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .din   (cs_n),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  assign frame_start = CS_ACTIVE_LOW ? cs_fall : cs_rise;
  assign frame_end   = CS_ACTIVE_LOW ? cs_rise : cs_fall;
  assign sck_lead    = (SPI_CPOL == 0) ? sck_rise : sck_fall;
  assign sck_trail   = (SPI_CPOL == 0) ? sck_fall : sck_rise;

  assign start_word  = hold_full ? holding : '0;
`ifdef SPI_SLAVE_OUT_PARITY_EN
  assign start_frame = {start_word, ~^start_word};
`else
  assign start_frame = start_word;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      holding   <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      bitcnt    <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_next;
      holding   <= holding_next;
      hold_full <= hold_full_next;
      shreg     <= shreg_next;
      bitcnt    <= bitcnt_next;
      done      <= done_next;
      aborted   <= aborted_next;
      underrun  <= underrun_next;
    end
  end

  always_comb begin
    state_next     = state;
    holding_next   = holding;
    hold_full_next = hold_full;
    shreg_next     = shreg;
    bitcnt_next    = bitcnt;
    done_next      = 1'b0;
    aborted_next   = 1'b0;
    underrun_next  = 1'b0;

    // A load can only coincide with a frame start when holding is empty,
    // so the frame sees the old (empty) state and the new word stays put.
    if (tx_valid && !hold_full) begin
      holding_next   = tx_data;
      hold_full_next = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          shreg_next    = start_frame;
          bitcnt_next   = '0;
          underrun_next = ~hold_full;
          if (hold_full) hold_full_next = 1'b0;
          state_next    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (frame_end) begin
          state_next   = ST_IDLE;
          shreg_next   = '0;
          done_next    = (bitcnt == CNT_FULL);
          aborted_next = (bitcnt != CNT_FULL);
        end else if (sck_lead) begin
          if (bitcnt != CNT_FULL) bitcnt_next = bitcnt + 1'b1;
        end else if (sck_trail) begin
          shreg_next = {shreg[FW-2:0], 1'b0};
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign miso     = (state == ST_SHIFT) & shreg[FW-1];
  assign busy     = (state == ST_SHIFT);
  assign tx_ready = ~hold_full;

endmodule
